// File: rtl/rtl_settings_pkg.sv
// Shared types and constants for the memory-test sequencer: mode encodings,
// FSM states and the 32-bit address LFSR polynomial.
package rtl_settings_pkg;

  typedef enum logic [1:0] {
    WRITE_ONLY      = 2'd0,
    READ_ONLY       = 2'd1,
    WRITE_AND_CHECK = 2'd2
  } test_mode_t;

  typedef enum logic [1:0] {
    FIX_ADDR = 2'd0,
    RUN_ADDR = 2'd1,
    RND_ADDR = 2'd2
  } addr_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam int LFSR_W = 32;

  // Taps 32,22,2,1 expressed as a bit mask over positions 31,21,1,0.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] state);
    return {state[LFSR_W-2:0], ^(state & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/test_sequencer_if.sv
// Request port between the test sequencer (master) and the transmitter
// block (slave): valid/busy handshake plus in-flight status.
interface test_sequencer_if #(
  parameter int ADDR_W = 31
);
  logic              trans_valid;
  logic [ADDR_W-1:0] trans_addr;
  logic              trans_type;
  logic              trans_block_busy;
  logic              in_process;

  modport master (
    output trans_valid,
    output trans_addr,
    output trans_type,
    input  trans_block_busy,
    input  in_process
  );

  modport slave (
    input  trans_valid,
    input  trans_addr,
    input  trans_type,
    output trans_block_busy,
    output in_process
  );
endinterface

// File: rtl/seq_lfsr_addr.sv
// 32-bit Fibonacci LFSR address source for RND_ADDR mode; only built when
// SEQ_RND_ADDR_EN is defined. Output is the current state truncated to OUT_W.
module seq_lfsr_addr
  import rtl_settings_pkg::*;
#(
  parameter int OUT_W = 31
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              adv_i,
  input  logic [LFSR_W-1:0] seed_i,
  output logic [OUT_W-1:0]  addr_o
);

  logic [LFSR_W-1:0] r_lfsr;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lfsr <= '0;
    end else if (load_i) begin
      r_lfsr <= seed_i;
    end else if (adv_i) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign addr_o = r_lfsr[OUT_W-1:0];

endmodule

// File: rtl/test_sequencer.sv
// Memory-test sequencer: issues programmed write/read requests to the
// transmitter, drains, and reports done/abort. SEQ_RND_ADDR_EN enables RND_ADDR.
module test_sequencer
  import rtl_settings_pkg::*;
#(
  parameter int ADDR_W = 31,
  parameter int CNT_W  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_test_i,
  input  test_mode_t           test_mode_i,
  input  addr_mode_t           addr_mode_i,
  input  logic [ADDR_W-1:0]    base_addr_i,
  input  logic [ADDR_W-1:0]    addr_step_i,
  input  logic [CNT_W-1:0]     trans_count_i,
  input  logic                 error_check_i,
  test_sequencer_if.master     trans,
  output logic                 test_busy_o,
  output logic                 test_done_o,
  output logic                 test_abort_o,
  output logic [CNT_W-1:0]     addr_done_cnt_o
);

  seq_state_t        r_state;
  seq_state_t        w_next_state;
  test_mode_t        r_test_mode;
  addr_mode_t        r_addr_mode;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_step;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_done_cnt;
  logic              r_phase;   // WRITE_AND_CHECK: 0 = write pending, 1 = read pending
  logic              r_abort;

  logic              w_start;
  logic              w_valid;
  logic              w_accept;
  logic              w_last_req;
  logic              w_addr_done;
  logic              w_set_abort;
  logic              w_type;
  logic [ADDR_W-1:0] w_addr;

  assign w_last_req  = (r_test_mode != WRITE_AND_CHECK) || r_phase;
  assign w_type      = (r_test_mode == READ_ONLY) ||
                       ((r_test_mode == WRITE_AND_CHECK) && r_phase);
  assign w_set_abort = error_check_i && ((r_state == ISSUE) || (r_state == DRAIN));

  // NOTE: every signal driven here gets a default first so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_valid      = 1'b0;
    w_accept     = 1'b0;
    w_addr_done  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start_test_i) begin
          w_start      = 1'b1;
          w_next_state = (trans_count_i == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        w_valid     = 1'b1;
        w_accept    = !trans.trans_block_busy;
        w_addr_done = w_accept && w_last_req;
        // An acceptance in the same cycle as an error still counts.
        if (error_check_i ||
            (w_addr_done && ((r_done_cnt + CNT_W'(1)) == r_count))) begin
          w_next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (!trans.in_process && !trans.trans_block_busy) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_test_mode <= WRITE_ONLY;
      r_addr_mode <= FIX_ADDR;
      r_addr      <= '0;
      r_step      <= '0;
      r_count     <= '0;
      r_done_cnt  <= '0;
      r_phase     <= 1'b0;
      r_abort     <= 1'b0;
    end else if (w_start) begin
      r_test_mode <= test_mode_i;
      r_addr_mode <= addr_mode_i;
      r_addr      <= base_addr_i;
      r_step      <= addr_step_i;
      r_count     <= trans_count_i;
      r_done_cnt  <= '0;
      r_phase     <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_last_req) begin
          r_phase    <= 1'b0;
          r_done_cnt <= r_done_cnt + CNT_W'(1);
          // Without the LFSR build, RND_ADDR falls through to running addresses.
          if (r_addr_mode != FIX_ADDR) begin
            r_addr <= r_addr + r_step;
          end
        end else begin
          r_phase <= 1'b1;
        end
      end
      if (w_set_abort) begin
        r_abort <= 1'b1;
      end
    end
  end

`ifdef SEQ_RND_ADDR_EN
  logic [ADDR_W-1:0] w_lfsr_addr;
  logic              w_lfsr_adv;

  assign w_lfsr_adv = w_addr_done && (r_addr_mode == RND_ADDR);

  // The seed itself is the first random address; each completed address steps once.
  seq_lfsr_addr #(
    .OUT_W (ADDR_W)
  ) u_lfsr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (w_start),
    .adv_i  (w_lfsr_adv),
    .seed_i (LFSR_W'(base_addr_i) | LFSR_W'(1)),
    .addr_o (w_lfsr_addr)
  );

  assign w_addr = (r_addr_mode == RND_ADDR) ? w_lfsr_addr : r_addr;
`else
  assign w_addr = r_addr;
`endif

  assign trans.trans_valid = w_valid;
  assign trans.trans_addr  = w_addr;
  assign trans.trans_type  = w_type;

  assign test_busy_o     = (r_state != IDLE);
  assign test_done_o     = (r_state == DONE);
  assign test_abort_o    = r_abort;
  assign addr_done_cnt_o = r_done_cnt;

endmodule
